// File: rtl/pipeline_stage_regs_pkg.sv
// pipeline_stage_regs_pkg: shared widths and reset constants for the forward pipeline registers.
// Rev 1.0
`default_nettype none

package pipeline_stage_regs_pkg;
  localparam int XLEN   = 64;
  localparam int ILEN   = 32;
  localparam int REG_AW = 5;
  localparam int ALUC_W = 4;
  localparam int MEMT_W = 3;
  localparam int RSLT_W = 3;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
endpackage

`default_nettype wire

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: one pipeline field register; priority is reset > clr > en.
// Rev 1.0
`default_nettype none

module pipe_field_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  // clr reuses the reset value so a flushed stage looks exactly like a reset one
  always_ff @(posedge clk) begin
    if (!reset)     r_q <= RST_VAL;
    else if (clr)   r_q <= RST_VAL;
    else if (en)    r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

`default_nettype wire

// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs: IF/ID, ID/EX and EX/MEM registers of the RV64 core.
// Optional hazard controls (stall_d, flush_d, flush_e) under macro PIPE_HAZARD_CTRL_EN. Rev 1.0
`default_nettype none

module pipeline_stage_regs
  import pipeline_stage_regs_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
`ifdef PIPE_HAZARD_CTRL_EN
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic              flush_e,
`endif
  input  logic [ILEN-1:0]   f_instr,
  input  logic [XLEN-1:0]   f_pc,
  input  logic [XLEN-1:0]   f_pc4,
  output logic [ILEN-1:0]   d_instr,
  output logic [XLEN-1:0]   d_pc,
  output logic [XLEN-1:0]   d_pc4,
  input  logic [2:0]        d_funct3,
  input  logic              d_alusrc,
  input  logic              d_alu32,
  input  logic              d_jal,
  input  logic              d_jalr,
  input  logic              d_branch,
  input  logic              d_memwrite,
  input  logic              d_regwrite,
  input  logic [ALUC_W-1:0] d_aluctrl,
  input  logic [MEMT_W-1:0] d_memtype,
  input  logic [RSLT_W-1:0] d_rsltsrc,
  input  logic [XLEN-1:0]   d_rd1,
  input  logic [XLEN-1:0]   d_rd2,
  input  logic [XLEN-1:0]   d_imm,
  input  logic [XLEN-1:0]   d_pcx,
  input  logic [XLEN-1:0]   d_pc4x,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic [REG_AW-1:0] d_rd,
  output logic [2:0]        e_funct3,
  output logic              e_alusrc,
  output logic              e_alu32,
  output logic              e_jal,
  output logic              e_jalr,
  output logic              e_branch,
  output logic              e_memwrite,
  output logic              e_regwrite,
  output logic [ALUC_W-1:0] e_aluctrl,
  output logic [MEMT_W-1:0] e_memtype,
  output logic [RSLT_W-1:0] e_rsltsrc,
  output logic [XLEN-1:0]   e_rd1,
  output logic [XLEN-1:0]   e_rd2,
  output logic [XLEN-1:0]   e_imm,
  output logic [XLEN-1:0]   e_pc,
  output logic [XLEN-1:0]   e_pc4,
  output logic [REG_AW-1:0] e_rs1,
  output logic [REG_AW-1:0] e_rs2,
  output logic [REG_AW-1:0] e_rd,
  input  logic              e_memwrite_i,
  input  logic              e_regwrite_i,
  input  logic [MEMT_W-1:0] e_memtype_i,
  input  logic [RSLT_W-1:0] e_rsltsrc_i,
  input  logic [XLEN-1:0]   e_alures,
  input  logic [XLEN-1:0]   e_wdata,
  input  logic [XLEN-1:0]   e_pctarget,
  input  logic [XLEN-1:0]   e_imm_i,
  input  logic [XLEN-1:0]   e_pc4_i,
  input  logic [REG_AW-1:0] e_rd_i,
  output logic              m_memwrite,
  output logic              m_regwrite,
  output logic [MEMT_W-1:0] m_memtype,
  output logic [RSLT_W-1:0] m_rsltsrc,
  output logic [XLEN-1:0]   m_alures,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN-1:0]   m_pctarget,
  output logic [XLEN-1:0]   m_imm,
  output logic [XLEN-1:0]   m_pc4,
  output logic [REG_AW-1:0] m_rd
);
  logic w_d_en;
  logic w_d_clr;
  logic w_e_clr;

`ifdef PIPE_HAZARD_CTRL_EN
  assign w_d_en  = ~stall_d;
  assign w_d_clr = flush_d;
  assign w_e_clr = flush_e;
`else
  assign w_d_en  = 1'b1;
  assign w_d_clr = 1'b0;
  assign w_e_clr = 1'b0;
`endif

  // IF/ID: the instruction field resets to a NOP, everything else to zero
  pipe_field_reg #(.WIDTH(ILEN), .RST_VAL(NOP_INSTR)) u_d_instr (.clk, .reset, .en(w_d_en), .clr(w_d_clr), .i_d(f_instr), .o_q(d_instr));
  pipe_field_reg #(.WIDTH(XLEN)) u_d_pc  (.clk, .reset, .en(w_d_en), .clr(w_d_clr), .i_d(f_pc),  .o_q(d_pc));
  pipe_field_reg #(.WIDTH(XLEN)) u_d_pc4 (.clk, .reset, .en(w_d_en), .clr(w_d_clr), .i_d(f_pc4), .o_q(d_pc4));

  // ID/EX: never stalled, only flushed to a bubble
  pipe_field_reg #(.WIDTH(3))      u_e_funct3   (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_funct3),   .o_q(e_funct3));
  pipe_field_reg #(.WIDTH(1))      u_e_alusrc   (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_alusrc),   .o_q(e_alusrc));
  pipe_field_reg #(.WIDTH(1))      u_e_alu32    (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_alu32),    .o_q(e_alu32));
  pipe_field_reg #(.WIDTH(1))      u_e_jal      (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_jal),      .o_q(e_jal));
  pipe_field_reg #(.WIDTH(1))      u_e_jalr     (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_jalr),     .o_q(e_jalr));
  pipe_field_reg #(.WIDTH(1))      u_e_branch   (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_branch),   .o_q(e_branch));
  pipe_field_reg #(.WIDTH(1))      u_e_memwrite (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_memwrite), .o_q(e_memwrite));
  pipe_field_reg #(.WIDTH(1))      u_e_regwrite (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_regwrite), .o_q(e_regwrite));
  pipe_field_reg #(.WIDTH(ALUC_W)) u_e_aluctrl  (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_aluctrl),  .o_q(e_aluctrl));
  pipe_field_reg #(.WIDTH(MEMT_W)) u_e_memtype  (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_memtype),  .o_q(e_memtype));
  pipe_field_reg #(.WIDTH(RSLT_W)) u_e_rsltsrc  (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_rsltsrc),  .o_q(e_rsltsrc));
  pipe_field_reg #(.WIDTH(XLEN))   u_e_rd1      (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_rd1),      .o_q(e_rd1));
  pipe_field_reg #(.WIDTH(XLEN))   u_e_rd2      (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_rd2),      .o_q(e_rd2));
  pipe_field_reg #(.WIDTH(XLEN))   u_e_imm      (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_imm),      .o_q(e_imm));
  pipe_field_reg #(.WIDTH(XLEN))   u_e_pc       (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_pcx),      .o_q(e_pc));
  pipe_field_reg #(.WIDTH(XLEN))   u_e_pc4      (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_pc4x),     .o_q(e_pc4));
  pipe_field_reg #(.WIDTH(REG_AW)) u_e_rs1      (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_rs1),      .o_q(e_rs1));
  pipe_field_reg #(.WIDTH(REG_AW)) u_e_rs2      (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_rs2),      .o_q(e_rs2));
  pipe_field_reg #(.WIDTH(REG_AW)) u_e_rd       (.clk, .reset, .en(1'b1), .clr(w_e_clr), .i_d(d_rd),       .o_q(e_rd));

  // EX/MEM: hazard controls do not reach this stage
  pipe_field_reg #(.WIDTH(1))      u_m_memwrite (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_memwrite_i), .o_q(m_memwrite));
  pipe_field_reg #(.WIDTH(1))      u_m_regwrite (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_regwrite_i), .o_q(m_regwrite));
  pipe_field_reg #(.WIDTH(MEMT_W)) u_m_memtype  (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_memtype_i),  .o_q(m_memtype));
  pipe_field_reg #(.WIDTH(RSLT_W)) u_m_rsltsrc  (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_rsltsrc_i),  .o_q(m_rsltsrc));
  pipe_field_reg #(.WIDTH(XLEN))   u_m_alures   (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_alures),     .o_q(m_alures));
  pipe_field_reg #(.WIDTH(XLEN))   u_m_wdata    (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_wdata),      .o_q(m_wdata));
  pipe_field_reg #(.WIDTH(XLEN))   u_m_pctarget (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_pctarget),   .o_q(m_pctarget));
  pipe_field_reg #(.WIDTH(XLEN))   u_m_imm      (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_imm_i),      .o_q(m_imm));
  pipe_field_reg #(.WIDTH(XLEN))   u_m_pc4      (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_pc4_i),      .o_q(m_pc4));
  pipe_field_reg #(.WIDTH(REG_AW)) u_m_rd       (.clk, .reset, .en(1'b1), .clr(1'b0), .i_d(e_rd_i),       .o_q(m_rd));
endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage_regs.sv
// tb_pipeline_stage_regs: random and directed checks of the pipeline stage registers against a snapshot model.
// Hazard-control checks are compiled in when PIPE_HAZARD_CTRL_EN is defined.
`default_nettype none

module tb_pipeline_stage_regs;
  import pipeline_stage_regs_pkg::*;

  localparam int IF_W = ILEN + 2*XLEN;
  localparam int ID_W = 3 + 7 + ALUC_W + MEMT_W + RSLT_W + 5*XLEN + 3*REG_AW;
  localparam int EX_W = 2 + MEMT_W + RSLT_W + 5*XLEN + REG_AW;
  localparam logic [IF_W-1:0] IF_RST = {NOP_INSTR, {(2*XLEN){1'b0}}};

  logic clk = 1'b0;
  logic reset;
  logic stall_d, flush_d, flush_e;
  logic [ILEN-1:0] f_instr, d_instr;
  logic [XLEN-1:0] f_pc, f_pc4, d_pc, d_pc4;
  logic [2:0] d_funct3, e_funct3;
  logic d_alusrc, d_alu32, d_jal, d_jalr, d_branch, d_memwrite, d_regwrite;
  logic e_alusrc, e_alu32, e_jal, e_jalr, e_branch, e_memwrite, e_regwrite;
  logic [ALUC_W-1:0] d_aluctrl, e_aluctrl;
  logic [MEMT_W-1:0] d_memtype, e_memtype, e_memtype_i, m_memtype;
  logic [RSLT_W-1:0] d_rsltsrc, e_rsltsrc, e_rsltsrc_i, m_rsltsrc;
  logic [XLEN-1:0] d_rd1, d_rd2, d_imm, d_pcx, d_pc4x, e_rd1, e_rd2, e_imm, e_pc, e_pc4;
  logic [REG_AW-1:0] d_rs1, d_rs2, d_rd, e_rs1, e_rs2, e_rd, e_rd_i, m_rd;
  logic e_memwrite_i, e_regwrite_i, m_memwrite, m_regwrite;
  logic [XLEN-1:0] e_alures, e_wdata, e_pctarget, e_imm_i, e_pc4_i;
  logic [XLEN-1:0] m_alures, m_wdata, m_pctarget, m_imm, m_pc4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_stage_regs dut (
    .clk(clk), .reset(reset),
`ifdef PIPE_HAZARD_CTRL_EN
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
`endif
    .f_instr(f_instr), .f_pc(f_pc), .f_pc4(f_pc4),
    .d_instr(d_instr), .d_pc(d_pc), .d_pc4(d_pc4),
    .d_funct3(d_funct3), .d_alusrc(d_alusrc), .d_alu32(d_alu32), .d_jal(d_jal), .d_jalr(d_jalr),
    .d_branch(d_branch), .d_memwrite(d_memwrite), .d_regwrite(d_regwrite),
    .d_aluctrl(d_aluctrl), .d_memtype(d_memtype), .d_rsltsrc(d_rsltsrc),
    .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm), .d_pcx(d_pcx), .d_pc4x(d_pc4x),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .e_funct3(e_funct3), .e_alusrc(e_alusrc), .e_alu32(e_alu32), .e_jal(e_jal), .e_jalr(e_jalr),
    .e_branch(e_branch), .e_memwrite(e_memwrite), .e_regwrite(e_regwrite),
    .e_aluctrl(e_aluctrl), .e_memtype(e_memtype), .e_rsltsrc(e_rsltsrc),
    .e_rd1(e_rd1), .e_rd2(e_rd2), .e_imm(e_imm), .e_pc(e_pc), .e_pc4(e_pc4),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_memwrite_i(e_memwrite_i), .e_regwrite_i(e_regwrite_i), .e_memtype_i(e_memtype_i),
    .e_rsltsrc_i(e_rsltsrc_i), .e_alures(e_alures), .e_wdata(e_wdata), .e_pctarget(e_pctarget),
    .e_imm_i(e_imm_i), .e_pc4_i(e_pc4_i), .e_rd_i(e_rd_i),
    .m_memwrite(m_memwrite), .m_regwrite(m_regwrite), .m_memtype(m_memtype), .m_rsltsrc(m_rsltsrc),
    .m_alures(m_alures), .m_wdata(m_wdata), .m_pctarget(m_pctarget), .m_imm(m_imm),
    .m_pc4(m_pc4), .m_rd(m_rd)
  );

  // Each stage viewed as one flat word: inputs on one side, outputs on the other
  logic [IF_W-1:0] if_in, if_out, exp_if;
  logic [ID_W-1:0] id_in, id_out, exp_id;
  logic [EX_W-1:0] ex_in, ex_out, exp_ex;
  logic            model_valid = 1'b0;

  assign if_in  = {f_instr, f_pc, f_pc4};
  assign if_out = {d_instr, d_pc, d_pc4};
  assign id_in  = {d_funct3, d_alusrc, d_alu32, d_jal, d_jalr, d_branch, d_memwrite, d_regwrite,
                   d_aluctrl, d_memtype, d_rsltsrc, d_rd1, d_rd2, d_imm, d_pcx, d_pc4x, d_rs1, d_rs2, d_rd};
  assign id_out = {e_funct3, e_alusrc, e_alu32, e_jal, e_jalr, e_branch, e_memwrite, e_regwrite,
                   e_aluctrl, e_memtype, e_rsltsrc, e_rd1, e_rd2, e_imm, e_pc, e_pc4, e_rs1, e_rs2, e_rd};
  assign ex_in  = {e_memwrite_i, e_regwrite_i, e_memtype_i, e_rsltsrc_i, e_alures, e_wdata,
                   e_pctarget, e_imm_i, e_pc4_i, e_rd_i};
  assign ex_out = {m_memwrite, m_regwrite, m_memtype, m_rsltsrc, m_alures, m_wdata,
                   m_pctarget, m_imm, m_pc4, m_rd};

  // Model: each stage shows a snapshot of what it saw at the last edge, subject to reset/flush/stall
  always @(posedge clk) begin
    if (!reset) begin
      exp_if = IF_RST;
      exp_id = '0;
      exp_ex = '0;
      model_valid = 1'b1;
    end else begin
`ifdef PIPE_HAZARD_CTRL_EN
      if (flush_d)       exp_if = IF_RST;
      else if (!stall_d) exp_if = if_in;
      exp_id = flush_e ? '0 : id_in;
`else
      exp_if = if_in;
      exp_id = id_in;
`endif
      exp_ex = ex_in;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    if (model_valid) begin
      total += 3;
      if (if_out !== exp_if) begin bad++; $display("FAIL model_ifid: got %h expected %h", if_out, exp_if); end
      if (id_out !== exp_id) begin bad++; $display("FAIL model_idex: got %h expected %h", id_out, exp_id); end
      if (ex_out !== exp_ex) begin bad++; $display("FAIL model_exmem: got %h expected %h", ex_out, exp_ex); end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic rand_inputs();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    {f_instr, f_pc, f_pc4} = r[IF_W-1:0];
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    {d_funct3, d_alusrc, d_alu32, d_jal, d_jalr, d_branch, d_memwrite, d_regwrite,
     d_aluctrl, d_memtype, d_rsltsrc, d_rd1, d_rd2, d_imm, d_pcx, d_pc4x, d_rs1, d_rs2, d_rd} = r[ID_W-1:0];
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    {e_memwrite_i, e_regwrite_i, e_memtype_i, e_rsltsrc_i, e_alures, e_wdata,
     e_pctarget, e_imm_i, e_pc4_i, e_rd_i} = r[EX_W-1:0];
  endtask

  task automatic set_all_ones();
    {f_instr, f_pc, f_pc4} = '1;
    {d_funct3, d_alusrc, d_alu32, d_jal, d_jalr, d_branch, d_memwrite, d_regwrite,
     d_aluctrl, d_memtype, d_rsltsrc, d_rd1, d_rd2, d_imm, d_pcx, d_pc4x, d_rs1, d_rs2, d_rd} = '1;
    {e_memwrite_i, e_regwrite_i, e_memtype_i, e_rsltsrc_i, e_alures, e_wdata,
     e_pctarget, e_imm_i, e_pc4_i, e_rd_i} = '1;
  endtask

  initial begin
    reset = 1'b0;
    stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
    set_all_ones();
    step();
    step();
    check("rst_d_instr", 64'(d_instr), 64'h13);
    check("rst_d_pc", d_pc, 64'h0);
    check("rst_e_rd1", e_rd1, 64'h0);
    check("rst_e_regwrite", 64'(e_regwrite), 64'h0);
    check("rst_e_jal", 64'(e_jal), 64'h0);
    check("rst_m_regwrite", 64'(m_regwrite), 64'h0);
    check("rst_m_memwrite", 64'(m_memwrite), 64'h0);
    check("rst_m_alures", m_alures, 64'h0);

    reset = 1'b1;
    f_instr = 32'h00A0_0093; f_pc = 64'h1000; f_pc4 = 64'h1004;
    d_rd1 = 64'hDEAD_BEEF_CAFE_F00D; d_rs1 = 5'd31; d_aluctrl = 4'hF; d_alu32 = 1'b1; d_rsltsrc = 3'b100;
    e_alures = 64'd1;
    step();
    check("pt_d_instr", 64'(d_instr), 64'h00A0_0093);
    check("pt_d_pc", d_pc, 64'h1000);
    check("pt_d_pc4", d_pc4, 64'h1004);
    check("idex_rd1", e_rd1, 64'hDEAD_BEEF_CAFE_F00D);
    check("idex_rs1", 64'(e_rs1), 64'd31);
    check("idex_aluctrl", 64'(e_aluctrl), 64'hF);
    check("idex_alu32", 64'(e_alu32), 64'h1);
    check("idex_rsltsrc", 64'(e_rsltsrc), 64'h4);
    check("stream_1", m_alures, 64'd1);
    e_alures = 64'd2;
    step();
    check("stream_2", m_alures, 64'd2);
    e_alures = 64'd3;
    step();
    check("stream_3", m_alures, 64'd3);

    e_alures = 64'd4; reset = 1'b0;
    step();
    check("midrst_m_alures", m_alures, 64'h0);
    check("midrst_d_instr", 64'(d_instr), 64'h13);
    check("midrst_e_rd1", e_rd1, 64'h0);
    reset = 1'b1; e_alures = 64'd5;
    step();
    check("resume_m_alures", m_alures, 64'd5);
    check("resume_e_rd1", e_rd1, 64'hDEAD_BEEF_CAFE_F00D);

    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      reset = ($urandom_range(15) != 0);
`ifdef PIPE_HAZARD_CTRL_EN
      stall_d = ($urandom_range(3) == 0);
      flush_d = ($urandom_range(5) == 0);
      flush_e = ($urandom_range(5) == 0);
`endif
      step();
    end
    reset = 1'b1;

`ifdef PIPE_HAZARD_CTRL_EN
    stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
    f_instr = 32'h0010_0113;
    step();
    f_instr = 32'h0020_0193; stall_d = 1'b1;
    step();
    check("stall_hold_1", 64'(d_instr), 64'h0010_0113);
    step();
    check("stall_hold_2", 64'(d_instr), 64'h0010_0113);
    stall_d = 1'b0;
    step();
    check("stall_release", 64'(d_instr), 64'h0020_0193);
    d_regwrite = 1'b1; d_rd = 5'd7; flush_e = 1'b1;
    step();
    check("flush_e_regwrite", 64'(e_regwrite), 64'h0);
    check("flush_e_rd", 64'(e_rd), 64'h0);
    flush_e = 1'b0; flush_d = 1'b1; stall_d = 1'b1;
    step();
    check("flush_over_stall", 64'(d_instr), 64'h13);
    check("flush_d_pc", d_pc, 64'h0);
    flush_d = 1'b0; stall_d = 1'b0;
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
